// File: rtl/snake_collision_check.sv
// Per-move collision checker: wall, self-body and apple tests for the snake head.
// Walks the segment store one entry per cycle with a single-cycle read latency.
module snake_collision_check #(
    parameter int MAXLEN  = 16,
    parameter int XDIM    = 10,
    parameter int YDIM    = 10,
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       start,
    input  logic [4:0] length,
    input  logic [7:0] head_x,
    input  logic [6:0] head_y,
    input  logic [7:0] apple_x,
    input  logic [6:0] apple_y,
    output logic [3:0] seg_idx,
    input  logic [7:0] seg_x,
    input  logic [6:0] seg_y,
    output logic       busy,
    output logic       done,
    output logic       hit_wall,
    output logic       hit_self,
    output logic       hit_apple
);

    typedef enum logic [1:0] {
        IDLE,
        EDGE,
        SCAN,
        DONE
    } state_t;

    typedef struct packed {
        logic [4:0] len;
        logic [7:0] hx;
        logic [6:0] hy;
        logic [7:0] ax;
        logic [6:0] ay;
    } req_t;

    localparam logic [4:0] LMAX = 5'(MAXLEN);
    localparam logic [8:0] XLIM = 9'(XSCREEN - XDIM);
    localparam logic [8:0] YLIM = 9'(YSCREEN - YDIM);
    localparam logic [8:0] XW   = 9'(XDIM);
    localparam logic [8:0] YW   = 9'(YDIM);

    state_t     state;
    req_t       req;
    logic [4:0] idx;

    logic [4:0] len_c;
    logic [8:0] hx9;
    logic [8:0] ax9;
    logic [8:0] hy9;
    logic [8:0] ay9;
    logic [8:0] dx;
    logic [8:0] dy;
    logic       wall_c;
    logic       apple_c;
    logic       match_c;

    // Length 0 behaves as a lone head; oversize lengths saturate at the store size.
    always_comb begin
        len_c = length;
        if (length == 5'd0) begin
            len_c = 5'd1;
        end else if (length > LMAX) begin
            len_c = LMAX;
        end
    end

    always_comb begin
        hx9 = {1'b0, req.hx};
        ax9 = {1'b0, req.ax};
        hy9 = {2'b00, req.hy};
        ay9 = {2'b00, req.ay};
        dx  = (hx9 >= ax9) ? (hx9 - ax9) : (ax9 - hx9);
        dy  = (hy9 >= ay9) ? (hy9 - ay9) : (ay9 - hy9);
    end

    assign wall_c  = (hx9 > XLIM) || (hy9 > YLIM);
    assign apple_c = (dx < XW) && (dy < YW);
    assign match_c = (seg_x == req.hx) && (seg_y == req.hy);
    assign seg_idx = idx[3:0];

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state     <= IDLE;
            req       <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit_wall  <= 1'b0;
            hit_self  <= 1'b0;
            hit_apple <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        req.len   <= len_c;
                        req.hx    <= head_x;
                        req.hy    <= head_y;
                        req.ax    <= apple_x;
                        req.ay    <= apple_y;
                        hit_wall  <= 1'b0;
                        hit_self  <= 1'b0;
                        hit_apple <= 1'b0;
                        idx       <= 5'd1;
                        busy      <= 1'b1;
                        state     <= EDGE;
                    end
                end
                EDGE: begin
                    hit_wall  <= wall_c;
                    hit_apple <= apple_c;
                    if (wall_c || req.len <= 5'd1) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= 5'd2;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    // Data on seg_x/seg_y belongs to segment idx-1.
                    if (match_c || idx == req.len) begin
                        hit_self <= match_c;
                        idx      <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_collision_check.sv
// Directed and randomized bench for snake_collision_check with a behavioural
// reference model of the collision rules.
module tb_snake_collision_check;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn;
    logic       start;
    logic [4:0] length;
    logic [7:0] head_x;
    logic [6:0] head_y;
    logic [7:0] apple_x;
    logic [6:0] apple_y;
    logic [3:0] seg_idx;
    logic [7:0] seg_x;
    logic [6:0] seg_y;
    logic       busy;
    logic       done;
    logic       hit_wall;
    logic       hit_self;
    logic       hit_apple;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_x [0:15];
    logic [6:0] mem_y [0:15];
    logic [3:0] idx_log [0:63];

    snake_collision_check dut (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .start    (start),
        .length   (length),
        .head_x   (head_x),
        .head_y   (head_y),
        .apple_x  (apple_x),
        .apple_y  (apple_y),
        .seg_idx  (seg_idx),
        .seg_x    (seg_x),
        .seg_y    (seg_y),
        .busy     (busy),
        .done     (done),
        .hit_wall (hit_wall),
        .hit_self (hit_self),
        .hit_apple(hit_apple)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Segment store: one-cycle registered read.
    always @(posedge CLOCK_50) begin
        seg_x <= mem_x[seg_idx];
        seg_y <= mem_y[seg_idx];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: rules of the game, computed with plain integer arithmetic.
    task automatic model(input int len, input int hx, input int hy,
                         input int ax, input int ay,
                         output int wall, output int self_hit,
                         output int apple, output int dcyc);
        int l;
        int dx;
        int dy;
        l = (len == 0) ? 1 : ((len > 16) ? 16 : len);
        wall = (hx > 150 || hy > 110) ? 1 : 0;
        dx = (hx > ax) ? hx - ax : ax - hx;
        dy = (hy > ay) ? hy - ay : ay - hy;
        apple = (dx < 10 && dy < 10) ? 1 : 0;
        self_hit = 0;
        if (wall == 1 || l <= 1) begin
            dcyc = 2;
        end else begin
            dcyc = l + 1;
            for (int k = 1; k < l; k++) begin
                if (int'(mem_x[k]) == hx && int'(mem_y[k]) == hy) begin
                    self_hit = 1;
                    dcyc = k + 2;
                    break;
                end
            end
        end
    endtask

    task automatic run(input string tag, input int len, input int hx,
                       input int hy, input int ax, input int ay,
                       input int repulse);
        int ew;
        int es;
        int ea;
        int ec;
        int dc;
        int busy_bad;
        model(len, hx, hy, ax, ay, ew, es, ea, ec);
        @(negedge CLOCK_50);
        length  = 5'(len);
        head_x  = 8'(hx);
        head_y  = 7'(hy);
        apple_x = 8'(ax);
        apple_y = 7'(ay);
        start   = 1'b1;
        dc = -1;
        busy_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLOCK_50);
            start = (c == repulse) ? 1'b1 : 1'b0;
            idx_log[c] = seg_idx;
            if (c < ec && busy !== 1'b1) busy_bad = 1;
            if (c >= ec && busy !== 1'b0) busy_bad = 1;
            if (done === 1'b1 && dc < 0) begin
                dc = c;
                check({tag, " wall"}, 32'(hit_wall), 32'(ew));
                check({tag, " self"}, 32'(hit_self), 32'(es));
                check({tag, " apple"}, 32'(hit_apple), 32'(ea));
            end
            if (c == ec + 1) begin
                check({tag, " pulse"}, 32'(done), 32'd0);
                check({tag, " hold"},
                      32'({hit_wall, hit_self, hit_apple}),
                      32'({ew[0], es[0], ea[0]}));
                break;
            end
        end
        start = 1'b0;
        check({tag, " done_cyc"}, 32'(dc), 32'(ec));
        check({tag, " busy"}, 32'(busy_bad), 32'd0);
    endtask

    task automatic fill_far();
        for (int i = 0; i < 16; i++) begin
            mem_x[i] = 8'd200;
            mem_y[i] = 7'd100;
        end
    endtask

    initial begin
        int hx;
        int hy;
        int dseen;
        Resetn  = 1'b0;
        start   = 1'b0;
        length  = '0;
        head_x  = '0;
        head_y  = '0;
        apple_x = '0;
        apple_y = '0;
        fill_far();
        repeat (3) @(negedge CLOCK_50);
        check("reset", 32'({seg_idx, busy, done, hit_wall, hit_self, hit_apple}),
              32'd0);
        Resetn = 1'b1;

        // Clear path with address sequence
        mem_x[1] = 8'd70; mem_y[1] = 7'd60;
        mem_x[2] = 8'd60; mem_y[2] = 7'd60;
        mem_x[3] = 8'd50; mem_y[3] = 7'd60;
        run("clear", 4, 80, 60, 20, 20, 0);
        check("clear seg_idx",
              32'({idx_log[1], idx_log[2], idx_log[3], idx_log[4], idx_log[5]}),
              32'h12340);

        run("wall_x", 4, 151, 60, 20, 20, 0);
        run("wall_y", 4, 80, 127, 20, 20, 0);
        run("apple_in", 4, 80, 60, 89, 60, 0);
        run("apple_out", 4, 80, 60, 90, 60, 0);

        fill_far();
        mem_x[1] = 8'd50; mem_y[1] = 7'd40;
        mem_x[2] = 8'd40; mem_y[2] = 7'd40;
        mem_x[4] = 8'd40; mem_y[4] = 7'd40;
        run("self", 6, 40, 40, 20, 20, 0);

        fill_far();
        run("len1", 1, 40, 40, 20, 20, 0);
        run("len0", 0, 40, 40, 20, 20, 0);
        run("len20", 20, 40, 40, 20, 20, 0);
        run("repulse", 8, 40, 40, 20, 20, 3);

        // Reset in cycle 3 of a length-8 check
        @(negedge CLOCK_50);
        length = 5'd8; head_x = 8'd40; head_y = 7'd40;
        apple_x = 8'd40; apple_y = 7'd40;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        Resetn = 1'b0;
        @(negedge CLOCK_50);
        check("midreset outs",
              32'({seg_idx, busy, done, hit_wall, hit_self, hit_apple}), 32'd0);
        Resetn = 1'b1;
        dseen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLOCK_50);
            if (done === 1'b1 || busy === 1'b1) dseen = 1;
        end
        check("midreset nodone", 32'(dseen), 32'd0);

        for (int r = 0; r < 60; r++) begin
            hx = ($urandom_range(0, 3) == 0) ? $urandom_range(140, 255)
                                             : $urandom_range(0, 150);
            hy = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 127)
                                             : $urandom_range(0, 110);
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    mem_x[i] = 8'(hx);
                    mem_y[i] = 7'(hy);
                end else begin
                    mem_x[i] = 8'(hx + $urandom_range(0, 2) - 1);
                    mem_y[i] = 7'(hy + $urandom_range(0, 2) - 1);
                end
            end
            run($sformatf("rand%0d", r), $urandom_range(0, 22), hx, hy,
                (hx + $urandom_range(0, 24) + 244) % 256,
                (hy + $urandom_range(0, 24) + 116) % 128, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
